// File: rtl/flow_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, threshold flags, flush and sticky error flags.
// Latency: a write is visible on dataOut one edge later; a pop exposes the next word on the same edge.
// Backpressure: none; a write when full is dropped (OVERWRITE=0) or evicts the oldest word (OVERWRITE=1).
module flow_fifo #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int OVERWRITE    = 0,
    parameter int ALMOST_FULL  = (1 << ADDRESS_SIZE) - 1,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WORD_SIZE-1:0]    dataIn,
    input  logic                    we,
    output logic [WORD_SIZE-1:0]    dataOut,
    input  logic                    oe,
    input  logic                    flush,
    input  logic                    clearFlags,
    output logic                    isData,
    output logic                    bufferFull,
    output logic                    almostFull,
    output logic                    almostEmpty,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    dataLost,
    output logic                    readError
);

    localparam int                  DEPTH     = 1 << ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] DEPTH_CNT = {1'b1, {ADDRESS_SIZE{1'b0}}};
    localparam logic [ADDRESS_SIZE:0] PTR_INC   = {{ADDRESS_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDRESS_SIZE:0] AF_TH     = ALMOST_FULL[ADDRESS_SIZE:0];
    localparam logic [ADDRESS_SIZE:0] AE_TH     = ALMOST_EMPTY[ADDRESS_SIZE:0];

    logic [WORD_SIZE-1:0]  mem_q [DEPTH];
    logic [ADDRESS_SIZE:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_SIZE:0] rd_ptr_q, rd_ptr_d;
    logic                  data_lost_q, data_lost_d;
    logic                  read_error_q, read_error_d;
    logic [ADDRESS_SIZE:0] cnt;
    logic                  full, empty;
    logic                  do_write, mem_we, lost_evt, rd_err_evt;

    // The extra pointer bit lets the difference distinguish full (DEPTH) from empty (0).
    assign cnt   = wr_ptr_q - rd_ptr_q;
    assign full  = (cnt == DEPTH_CNT);
    assign empty = (cnt == '0);

    always_comb begin
        do_write     = we && (!full || oe || (OVERWRITE != 0));
        lost_evt     = we && full && !oe;
        rd_err_evt   = oe && empty;
        mem_we       = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_lost_d  = clearFlags ? 1'b0 : data_lost_q;
        read_error_d = clearFlags ? 1'b0 : read_error_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            mem_we = do_write;
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_INC;
            end
            // Overwrite-on-full evicts the oldest word by advancing the read side too.
            if ((oe && !empty) || (lost_evt && (OVERWRITE != 0))) begin
                rd_ptr_d = rd_ptr_q + PTR_INC;
            end
            if (lost_evt) begin
                data_lost_d = 1'b1;
            end
            if (rd_err_evt) begin
                read_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_lost_q  <= 1'b0;
            read_error_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_lost_q  <= data_lost_d;
            read_error_q <= read_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[wr_ptr_q[ADDRESS_SIZE-1:0]] <= dataIn;
        end
    end

    assign dataOut     = empty ? '0 : mem_q[rd_ptr_q[ADDRESS_SIZE-1:0]];
    assign isData      = !empty;
    assign bufferFull  = full;
    assign almostFull  = (cnt >= AF_TH);
    assign almostEmpty = (cnt <= AE_TH);
    assign count       = cnt;
    assign dataLost    = data_lost_q;
    assign readError   = read_error_q;

endmodule

// File: tb/tb_flow_fifo.sv
// Directed bench for flow_fifo: drop-on-full and overwrite-on-full instances share one stimulus stream.
module tb_flow_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dataIn;
    logic       we, oe, flush, clearFlags;

    logic [7:0] d_dout, o_dout;
    logic       d_isdata, d_full, d_af, d_ae, d_lost, d_rerr;
    logic       o_isdata, o_full, o_af, o_ae, o_lost, o_rerr;
    logic [2:0] d_cnt, o_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flow_fifo #(.WORD_SIZE(8), .ADDRESS_SIZE(2), .OVERWRITE(0), .ALMOST_FULL(3), .ALMOST_EMPTY(1)) u_drop (
        .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .we(we), .dataOut(d_dout), .oe(oe),
        .flush(flush), .clearFlags(clearFlags), .isData(d_isdata), .bufferFull(d_full),
        .almostFull(d_af), .almostEmpty(d_ae), .count(d_cnt), .dataLost(d_lost), .readError(d_rerr)
    );

    flow_fifo #(.WORD_SIZE(8), .ADDRESS_SIZE(2), .OVERWRITE(1), .ALMOST_FULL(3), .ALMOST_EMPTY(1)) u_ovw (
        .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .we(we), .dataOut(o_dout), .oe(oe),
        .flush(flush), .clearFlags(clearFlags), .isData(o_isdata), .bufferFull(o_full),
        .almostFull(o_af), .almostEmpty(o_ae), .count(o_cnt), .dataLost(o_lost), .readError(o_rerr)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
        we = 1'b0; oe = 1'b0; flush = 1'b0; clearFlags = 1'b0; rst_n = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
    endtask

    task automatic push(input logic [7:0] v);
        dataIn = v; we = 1'b1;
        cycle();
    endtask

    task automatic pop();
        oe = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (d_cnt !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", d_cnt); end
        checks++; if (d_isdata !== 1'b0 || d_full !== 1'b0) begin failures++; $display("FAIL rst_isdata_full got=%b%b exp=00", d_isdata, d_full); end
        checks++; if (d_af !== 1'b0 || d_ae !== 1'b1) begin failures++; $display("FAIL rst_af_ae got=%b%b exp=01", d_af, d_ae); end
        checks++; if (d_dout !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=00", d_dout); end
        checks++; if (d_lost !== 1'b0 || d_rerr !== 1'b0) begin failures++; $display("FAIL rst_sticky got=%b%b exp=00", d_lost, d_rerr); end
        checks++; if (o_cnt !== 3'd0 || o_ae !== 1'b1) begin failures++; $display("FAIL rst_ovw got cnt=%0d ae=%b exp cnt=0 ae=1", o_cnt, o_ae); end
    endtask

    task automatic test_full_drop_overwrite();
        logic [7:0] exp_d [4];
        logic [7:0] exp_o [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_o = '{8'h22, 8'h33, 8'h44, 8'h55};
        do_reset();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        checks++; if (d_cnt !== 3'd4 || d_full !== 1'b1) begin failures++; $display("FAIL fill_full got cnt=%0d full=%b exp cnt=4 full=1", d_cnt, d_full); end
        checks++; if (d_dout !== 8'h11 || o_dout !== 8'h11) begin failures++; $display("FAIL fill_head got drop=%h ovw=%h exp 11", d_dout, o_dout); end
        checks++; if (d_lost !== 1'b0) begin failures++; $display("FAIL fill_nolost got=%b exp=0", d_lost); end
        push(8'h55);
        checks++; if (d_cnt !== 3'd4 || d_lost !== 1'b1 || d_dout !== 8'h11) begin failures++; $display("FAIL drop_on_full got cnt=%0d lost=%b dout=%h exp 4 1 11", d_cnt, d_lost, d_dout); end
        checks++; if (o_cnt !== 3'd4 || o_lost !== 1'b1 || o_dout !== 8'h22) begin failures++; $display("FAIL ovw_on_full got cnt=%0d lost=%b dout=%h exp 4 1 22", o_cnt, o_lost, o_dout); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (d_dout !== exp_d[i]) begin failures++; $display("FAIL drop_pop%0d got=%h exp=%h", i, d_dout, exp_d[i]); end
            checks++; if (o_dout !== exp_o[i]) begin failures++; $display("FAIL ovw_pop%0d got=%h exp=%h", i, o_dout, exp_o[i]); end
            pop();
        end
        checks++; if (d_isdata !== 1'b0 || d_dout !== 8'h00 || o_isdata !== 1'b0 || o_dout !== 8'h00) begin failures++; $display("FAIL drained got isdata=%b%b dout=%h/%h exp 0 00", d_isdata, o_isdata, d_dout, o_dout); end
        checks++; if (d_rerr !== 1'b0) begin failures++; $display("FAIL drained_rerr got=%b exp=0", d_rerr); end
        clearFlags = 1'b1;
        cycle();
        checks++; if (d_lost !== 1'b0 || o_lost !== 1'b0) begin failures++; $display("FAIL clear_lost got=%b%b exp=00", d_lost, o_lost); end
    endtask

    task automatic test_wrap();
        int max_cnt;
        do_reset();
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            push(8'(i));
            if (int'(d_cnt) > max_cnt) max_cnt = int'(d_cnt);
            checks++; if (d_dout !== 8'(i)) begin failures++; $display("FAIL wrap_data%0d got=%h exp=%h", i, d_dout, 8'(i)); end
            pop();
        end
        checks++; if (max_cnt !== 1) begin failures++; $display("FAIL wrap_maxcnt got=%0d exp=1", max_cnt); end
        checks++; if (d_lost !== 1'b0 || d_rerr !== 1'b0 || d_isdata !== 1'b0) begin failures++; $display("FAIL wrap_flags got lost=%b rerr=%b isdata=%b exp 000", d_lost, d_rerr, d_isdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        dataIn = 8'hB0; we = 1'b1; oe = 1'b1;
        cycle();
        checks++; if (d_cnt !== 3'd4 || d_lost !== 1'b0 || o_cnt !== 3'd4 || o_lost !== 1'b0) begin failures++; $display("FAIL simul_full got cnt=%0d/%0d lost=%b/%b exp 4 0", d_cnt, o_cnt, d_lost, o_lost); end
        checks++; if (d_dout !== 8'hA1 || o_dout !== 8'hA1) begin failures++; $display("FAIL simul_full_head got=%h/%h exp=a1", d_dout, o_dout); end
        pop(); pop(); pop();
        checks++; if (d_dout !== 8'hB0 || d_cnt !== 3'd1) begin failures++; $display("FAIL simul_full_tail got dout=%h cnt=%0d exp b0 1", d_dout, d_cnt); end
        pop();
        dataIn = 8'h5A; we = 1'b1; oe = 1'b1;
        cycle();
        checks++; if (d_cnt !== 3'd1 || d_rerr !== 1'b1 || d_dout !== 8'h5A) begin failures++; $display("FAIL simul_empty got cnt=%0d rerr=%b dout=%h exp 1 1 5a", d_cnt, d_rerr, d_dout); end
        checks++; if (d_lost !== 1'b0) begin failures++; $display("FAIL simul_empty_lost got=%b exp=0", d_lost); end
        pop();
        oe = 1'b1; clearFlags = 1'b1;
        cycle();
        checks++; if (d_rerr !== 1'b1) begin failures++; $display("FAIL clear_vs_set got=%b exp=1", d_rerr); end
        clearFlags = 1'b1;
        cycle();
        checks++; if (d_rerr !== 1'b0) begin failures++; $display("FAIL clear_rerr got=%b exp=0", d_rerr); end
    endtask

    task automatic test_thresholds();
        logic exp_ae [5];
        logic exp_af [5];
        exp_ae = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_af = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++; if (d_cnt !== 3'(i) || d_ae !== exp_ae[i] || d_af !== exp_af[i]) begin failures++; $display("FAIL thresh%0d got cnt=%0d ae=%b af=%b exp cnt=%0d ae=%b af=%b", i, d_cnt, d_ae, d_af, i, exp_ae[i], exp_af[i]); end
            if (i < 4) push(8'hC0 + 8'(i));
        end
    endtask

    task automatic test_flush();
        do_reset();
        push(8'h01); push(8'h02); push(8'h03);
        flush = 1'b1; dataIn = 8'h77; we = 1'b1;
        cycle();
        checks++; if (d_cnt !== 3'd0 || d_isdata !== 1'b0 || d_dout !== 8'h00) begin failures++; $display("FAIL flush got cnt=%0d isdata=%b dout=%h exp 0 0 00", d_cnt, d_isdata, d_dout); end
        push(8'h9C);
        checks++; if (d_dout !== 8'h9C || d_cnt !== 3'd1) begin failures++; $display("FAIL post_flush got dout=%h cnt=%0d exp 9c 1", d_dout, d_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pop();
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4); push(8'hE5);
        checks++; if (d_rerr !== 1'b1 || d_lost !== 1'b1) begin failures++; $display("FAIL pre_reset_sticky got rerr=%b lost=%b exp 11", d_rerr, d_lost); end
        rst_n = 1'b0; dataIn = 8'hFF; we = 1'b1;
        cycle();
        checks++; if (d_cnt !== 3'd0 || d_isdata !== 1'b0 || d_full !== 1'b0 || d_dout !== 8'h00) begin failures++; $display("FAIL mid_reset_data got cnt=%0d isdata=%b full=%b dout=%h exp 0 0 0 00", d_cnt, d_isdata, d_full, d_dout); end
        checks++; if (d_rerr !== 1'b0 || d_lost !== 1'b0 || d_ae !== 1'b1 || d_af !== 1'b0) begin failures++; $display("FAIL mid_reset_flags got rerr=%b lost=%b ae=%b af=%b exp 0 0 1 0", d_rerr, d_lost, d_ae, d_af); end
    endtask

    initial begin
        rst_n = 1'b0; dataIn = 8'h00; we = 1'b0; oe = 1'b0; flush = 1'b0; clearFlags = 1'b0;
        #2;
        test_reset();
        test_full_drop_overwrite();
        test_wrap();
        test_back_to_back();
        test_thresholds();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
